// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg: shared types and helpers for the UART frame receiver    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Payload is zero-extended to 9 bits; padding does not affect the XOR.
  function automatic logic parity_error_calc(input int mode, input logic [8:0] data,
                                             input logic par_bit);
    logic even_err;
    even_err = par_bit ^ (^data);
    case (mode)
      PARITY_EVEN: return even_err;
      PARITY_ODD:  return ~even_err;
      default:     return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_sync: 2-flop RX synchroniser with optional 2-of-3 filter  |
// | Macro: UART_RX_MAJORITY_EN selects the majority-filtered bit.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_rx_sync (
  input  logic clk_3125,
  input  logic rst_n,
  input  logic rx,
  output logic rxs,
  output logic rx_bit
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign rxs = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rxs one cycle ago, hist_q[1] two cycles ago.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = {hist_q[0], sync2_q};
  end

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rx_bit = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rx_bit = sync2_q;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_frame: parametrised UART receiver (width/parity/stop)     |
// | Macro: UART_RX_MAJORITY_EN enables 2-of-3 bit decisions.          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 27,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_3125,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] c_half_m1   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] c_bit_m1    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       c_last_bit  = 4'(DATA_BITS - 1);
  localparam logic             c_last_stop = 1'(STOP_BITS - 1);

  logic rxs;
  logic rx_bit;

  uart_rx_sync u_sync (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .rx       (rx),
    .rxs      (rxs),
    .rx_bit   (rx_bit)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shr_q, shr_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_parity_q, rx_parity_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 framing_error_q, framing_error_d;
  logic                 ferr_now;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_W'(1);
    bit_idx_d       = bit_idx_q;
    stop_idx_d      = stop_idx_q;
    shr_d           = shr_q;
    par_d           = par_q;
    ferr_d          = ferr_q;
    rx_data_d       = rx_data_q;
    rx_parity_d     = rx_parity_q;
    rx_valid_d      = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    ferr_now        = ferr_q | ~rx_bit;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == c_half_m1) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          ferr_d     = 1'b0;
          par_d      = 1'b0;
          state_d    = rx_bit ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == c_bit_m1) begin
          cnt_d     = '0;
          shr_d     = {rx_bit, shr_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == c_last_bit) begin
            state_d = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (cnt_q == c_bit_m1) begin
          cnt_d   = '0;
          par_d   = rx_bit;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (cnt_q == c_bit_m1) begin
          cnt_d  = '0;
          ferr_d = ferr_now;
          if (stop_idx_q == c_last_stop) begin
            // Frame complete: publish everything on this edge, errors included.
            rx_data_d       = shr_q;
            rx_parity_d     = (PARITY_MODE != PARITY_NONE) ? par_q : 1'b0;
            parity_error_d  = parity_error_calc(PARITY_MODE, 9'(shr_q), par_q);
            framing_error_d = ferr_now;
            rx_valid_d      = 1'b1;
            state_d         = ferr_now ? S_BREAK : S_IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      stop_idx_q      <= 1'b0;
      shr_q           <= '0;
      par_q           <= 1'b0;
      ferr_q          <= 1'b0;
      rx_data_q       <= '0;
      rx_parity_q     <= 1'b0;
      rx_valid_q      <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      stop_idx_q      <= stop_idx_d;
      shr_q           <= shr_d;
      par_q           <= par_d;
      ferr_q          <= ferr_d;
      rx_data_q       <= rx_data_d;
      rx_parity_q     <= rx_parity_d;
      rx_valid_q      <= rx_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_parity     = rx_parity_q;
  assign rx_valid      = rx_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_rx_frame: directed + random frames against a bit model    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_rx_frame;

  localparam int CPB  = 27;
  localparam int HALF = CPB / 2;

  logic       clk_3125 = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [7:0] a_data;
  logic [6:0] b_data;
  logic       a_par, a_valid, a_perr, a_ferr, a_busy;
  logic       b_par, b_valid, b_perr, b_ferr, b_busy;

  always #5 clk_3125 = ~clk_3125;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_a (
    .clk_3125(clk_3125), .rst_n(rst_n), .rx(rx_a), .rx_data(a_data), .rx_parity(a_par),
    .rx_valid(a_valid), .parity_error(a_perr), .framing_error(a_ferr), .busy(a_busy)
  );

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_b (
    .clk_3125(clk_3125), .rst_n(rst_n), .rx(rx_b), .rx_data(b_data), .rx_parity(b_par),
    .rx_valid(b_valid), .parity_error(b_perr), .framing_error(b_ferr), .busy(b_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int a_vcnt = 0, b_vcnt = 0, a_vcyc = 0, b_vcyc = 0;

  always @(posedge clk_3125) cyc <= cyc + 1;

  always @(negedge clk_3125) begin
    if (a_valid) begin
      a_vcnt <= a_vcnt + 1;
      a_vcyc <= cyc;
    end
    if (b_valid) begin
      b_vcnt <= b_vcnt + 1;
      b_vcyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_3125);
    #1;
  endtask

  // Serialise one frame, then compare against values derived from the frame bits.
  task automatic send_frame(input int which, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input int hold_low, input string tag);
    int dbits, pmode, nstop, nbits, v0, start, lat, base, ones, obs_cnt;
    logic [15:0] bits;
    logic [8:0]  dmask;
    logic        exp_perr, exp_ferr, exp_par, obs_busy;
    logic [31:0] obs_data, obs_par, obs_perr, obs_ferr;
    dbits = (which == 0) ? 8 : 7;
    pmode = (which == 0) ? 1 : 2;
    nstop = (which == 0) ? 1 : 2;
    dmask = data & 9'((1 << dbits) - 1);
    bits  = '0;
    nbits = 1;
    for (int i = 0; i < dbits; i++) begin
      bits[nbits] = dmask[i];
      nbits++;
    end
    if (pmode != 0) begin
      bits[nbits] = pbit;
      nbits++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[nbits] = stops[i];
      nbits++;
    end
    v0    = (which == 0) ? a_vcnt : b_vcnt;
    start = cyc;
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, bits[i]);
      tick(CPB);
    end
    if (hold_low > 0) begin
      set_rx(which, 1'b0);
      tick(hold_low);
      obs_busy = (which == 0) ? a_busy : b_busy;
      check({tag, ".busy_held"}, 32'(obs_busy), 32'd1);
    end
    set_rx(which, 1'b1);
    tick(2 * CPB);

    ones     = $countones(dmask) + int'(pbit);
    exp_perr = (pmode == 1) ? (ones % 2 == 1) : (pmode == 2) ? (ones % 2 == 0) : 1'b0;
    exp_par  = (pmode != 0) ? pbit : 1'b0;
    exp_ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    base     = HALF + (dbits + int'(pmode != 0) + nstop) * CPB;

    if (which == 0) begin
      obs_cnt = a_vcnt - v0; lat = a_vcyc - start;
      obs_data = 32'(a_data); obs_par = 32'(a_par); obs_perr = 32'(a_perr); obs_ferr = 32'(a_ferr);
    end else begin
      obs_cnt = b_vcnt - v0; lat = b_vcyc - start;
      obs_data = 32'(b_data); obs_par = 32'(b_par); obs_perr = 32'(b_perr); obs_ferr = 32'(b_ferr);
    end
    check({tag, ".valid_cnt"}, 32'(obs_cnt), 32'd1);
    check({tag, ".data"}, obs_data, 32'(dmask));
    check({tag, ".parity"}, obs_par, 32'(exp_par));
    check({tag, ".perr"}, obs_perr, 32'(exp_perr));
    check({tag, ".ferr"}, obs_ferr, 32'(exp_ferr));
    check({tag, ".lat_in_window"}, 32'(lat >= base + 1 && lat <= base + 3), 32'd1);
  endtask

  initial begin
    int v0;
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    tick(3);
    check("rst.data_a", 32'(a_data), 32'd0);
    check("rst.flags_a", {27'd0, a_par, a_valid, a_perr, a_ferr, a_busy}, 32'd0);
    check("rst.data_b", 32'(b_data), 32'd0);
    check("rst.flags_b", {27'd0, b_par, b_valid, b_perr, b_ferr, b_busy}, 32'd0);
    rst_n = 1'b1;
    tick(4);

    send_frame(0, 9'h0A5, 1'b0, 2'b11, 0, "t1_a5");
    send_frame(0, 9'h03C, 1'b1, 2'b11, 0, "t2_3c");

    // Short glitch must be rejected as a false start.
    v0 = a_vcnt;
    rx_a = 1'b0;
    tick(5);
    rx_a = 1'b1;
    tick(16);
    check("t3.busy", 32'(a_busy), 32'd0);
    check("t3.valid_cnt", 32'(a_vcnt - v0), 32'd0);
    check("t3.data_hold", 32'(a_data), 32'h3C);
    check("t3.perr_hold", 32'(a_perr), 32'd1);
    tick(CPB);

    send_frame(0, 9'h055, 1'b0, 2'b10, 600, "t4_break");
    send_frame(0, 9'h00F, 1'b0, 2'b11, 0, "t4_0f");

    // Abort a frame during data bit 3 with reset (0x81: bits 1,0,0,0 ...).
    v0 = a_vcnt;
    rx_a = 1'b0; tick(CPB);
    rx_a = 1'b1; tick(CPB);
    rx_a = 1'b0; tick(CPB);
    rx_a = 1'b0; tick(CPB);
    rx_a = 1'b0; tick(10);
    rst_n = 1'b0;
    rx_a  = 1'b1;
    tick(1);
    check("t5.data_rst", 32'(a_data), 32'd0);
    check("t5.flags_rst", {27'd0, a_par, a_valid, a_perr, a_ferr, a_busy}, 32'd0);
    rst_n = 1'b1;
    tick(2 * CPB);
    check("t5.no_valid", 32'(a_vcnt - v0), 32'd0);
    send_frame(0, 9'h081, 1'b0, 2'b11, 0, "t5_81");

    for (int i = 0; i < 8; i++) begin
      send_frame(0, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 {1'b1, 1'($urandom_range(0, 3) != 0)}, 0, $sformatf("rnd_a%0d", i));
    end

    send_frame(1, 9'h041, 1'b1, 2'b01, 0, "t6_41");

    for (int i = 0; i < 4; i++) begin
      send_frame(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(1, 3)), 0, $sformatf("rnd_b%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver: the next generation of the fixed 8-bit/even-parity receiver in the `clk_3125` serial subsystem. It recovers asynchronous frames with configurable data width, parity mode and stop-bit count. It adds input synchronisation, false-start rejection, framing-error detection and break handling. It sits between the board RX pin and the message/command parsers, which consume `rx_data` on the `rx_valid` pulse.

## Interface
- `CLKS_PER_BIT`, default 27: clock cycles per bit (3.125 MHz / 115200). Must be ≥ 8.
- `DATA_BITS`, default 8: payload bits, 5..9, sent LSB first.
- `PARITY_MODE`, default 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk_3125`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `rx`  in  1: asynchronous serial line, idle high.
- `rx_data`  out  DATA_BITS: last received payload.
- `rx_parity`  out  1: last received parity bit; 0 when PARITY_MODE = 0.
- `rx_valid`  out  1: one-cycle pulse when a frame completes.
- `parity_error`  out  1: parity mismatch on the last frame.
- `framing_error`  out  1: a stop bit sampled low on the last frame.
- `busy`  out  1: FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised value `rxs`.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. `HALF = CLKS_PER_BIT/2`, integer floor.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when `rxs` = 0, clear `cnt` and go to START.
- START: at `cnt` = HALF-1, take the bit decision.
  - Decision 1 (false start): go to IDLE with no output activity.
  - Decision 0: clear `cnt` and the bit index, then go to DATA.
- DATA: at `cnt` = CLKS_PER_BIT-1, shift the decision in LSB first. After DATA_BITS bits, go to PARITY if PARITY_MODE ≠ 0, otherwise go to STOP.
- PARITY: at the mid-bit point, capture the parity bit, then go to STOP.
- STOP: sample STOP_BITS bits at their mid-bit points. Any 0 sets the frame's framing flag. After the last stop sample, in the same edge:
  - Load `rx_data`, `rx_parity`, `parity_error`, `framing_error`.
  - Pulse `rx_valid`.
  - Go to IDLE if the framing flag is clear, otherwise go to BREAK.
- BREAK: wait until `rxs` = 1, then go to IDLE. A held-low line never produces a second frame.
- Parity rules:
  - Even: `parity_error` = `rx_parity` XOR (XOR-reduce of `rx_data`).
  - Odd: the inverse of the even result.
  - None: `parity_error` stays 0.
- Outputs hold their values until the next completed frame. `rx_valid` fires even when an error flag is set.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0, shift register 0, synchroniser flops 1.
- Reset mid-frame aborts the frame. No `rx_valid` is produced, and the next falling edge starts a fresh frame.
- `rx_valid` is high for exactly one cycle, on the edge that samples the final stop bit.
- Latency from the `rx` falling edge to `rx_valid`: 2 + HALF + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT cycles ±1, where P = (PARITY_MODE ≠ 0).
- Data outputs and error flags change only on the `rx_valid` edge.
- Back-to-back frames are supported: the FSM is in IDLE half a bit before the next start edge.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit decision is the 2-of-3 majority of samples at `cnt` = M-2, M-1 and M, where M is the decision point (HALF-1 for start, CLKS_PER_BIT-1 otherwise). This filters single-cycle glitches.
- `UART_RX_MAJORITY_EN` undefined: the decision is the single sample at M. Sampling points and latency are identical in both builds.

## Structure
- Package `uart_pkg` holds:
  - The FSM state enum.
  - `PARITY_NONE`/`PARITY_EVEN`/`PARITY_ODD` constants.
  - A parity-function helper.
- Sub-module `uart_rx_sync` contains the 2-flop synchroniser plus the 3-sample majority filter (the latter under the macro). It outputs `rxs` and the filtered bit.
- The FSM, counters and output registers live in `uart_rx_frame`.

## Test plan
Defaults for scenarios 1–5 are 27 / 8 / even / 1.
1. Send 0xA5, parity 0, stop 1 → `rx_data` = 0xA5, `parity_error` = 0, `framing_error` = 0, one `rx_valid` pulse.
2. Send 0x3C with parity bit 1 → `rx_data` = 0x3C, `parity_error` = 1.
3. 5-cycle low glitch on an idle line → no `rx_valid`; `busy` deasserts within 16 cycles.
4. Send 0x55 with stop bit 0, then hold the line low for 600 cycles → one `rx_valid` with `framing_error` = 1 and no further frames. Release the line, send 0x0F → `rx_data` = 0x0F, `framing_error` = 0.
5. Pull `rst_n` low during data bit 3 → all outputs 0 on the next edge; a following frame 0x81 is received correctly.
6. DATA_BITS = 7, odd parity, STOP_BITS = 2: send 0x41 with parity 1 and second stop bit 0 → `rx_data` = 0x41, `parity_error` = 0, `framing_error` = 1.
